// File: rtl/alu_div_seq_pkg.sv
// Shared definitions for the sequential divider: ALU opcodes, divide op encodings, FSM states.
package alu_div_seq_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;

  typedef enum logic [1:0] {
    DIVOP_DIV  = 2'd0,
    DIVOP_DIVU = 2'd1,
    DIVOP_REM  = 2'd2,
    DIVOP_REMU = 2'd3
  } div_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_NEG_A,
    ST_NEG_B,
    ST_CMP,
    ST_SUB,
    ST_FIX,
    ST_DONE
  } div_state_e;

  function automatic logic op_is_signed(input div_op_e op);
    return (op == DIVOP_DIV) || (op == DIVOP_REM);
  endfunction

  function automatic logic op_is_quot(input div_op_e op);
    return (op == DIVOP_DIV) || (op == DIVOP_DIVU);
  endfunction

endpackage

// File: rtl/alu_div_seq.sv
// Restoring divider for DIV/DIVU/REM/REMU that borrows the shared ALU one operation per cycle.
module alu_div_seq
  import alu_div_seq_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            RESET_N,
  input  logic            START,
  input  logic [1:0]      OP_SEL,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic            BUSY,
  output logic            DONE,
  output logic [XLEN-1:0] RESULT,
  output logic            ALU_REQ,
  input  logic            ALU_GNT,
  output logic [31:0]     ALU_X,
  output logic [31:0]     ALU_Y,
  output logic [3:0]      ALU_OP,
  input  logic [31:0]     ALU_RESULT
);

  div_state_e      state_q, state_d;
  div_op_e         op_q;
  logic [XLEN-1:0] a_q, b_q, rem_q, q_q, result_q;
  logic [4:0]      count_q;
  logic            neg_q_q, neg_r_q;

  div_op_e         op_in;
  logic            sgn_in, quot_in, ovf_in;
  logic            sgn, quot, last, fix_needed, lt;
  logic [XLEN-1:0] rs, bit_mask, q_set, q_clr;
  div_state_e      step_next;

  assign op_in   = div_op_e'(OP_SEL);
  assign sgn_in  = op_is_signed(op_in);
  assign quot_in = op_is_quot(op_in);
  assign ovf_in  = sgn_in && (A == {1'b1, {(XLEN-1){1'b0}}}) && (B == '1);

  assign sgn        = op_is_signed(op_q);
  assign quot       = op_is_quot(op_q);
  assign last       = (count_q == '0);
  assign fix_needed = quot ? neg_q_q : neg_r_q;
  assign lt         = ALU_RESULT[0];

  // Shift the next dividend bit into the partial remainder.
  assign rs       = {rem_q[XLEN-2:0], a_q[count_q]};
  assign bit_mask = XLEN'(1) << count_q;
  assign q_set    = q_q | bit_mask;
  assign q_clr    = q_q & ~bit_mask;

  assign step_next = last ? (fix_needed ? ST_FIX : ST_DONE) : ST_CMP;

  assign BUSY   = (state_q != ST_IDLE);
  assign DONE   = (state_q == ST_DONE);
  assign RESULT = result_q;

  always_comb begin
    state_d = state_q;
    ALU_REQ = 1'b0;
    ALU_X   = '0;
    ALU_Y   = '0;
    ALU_OP  = ALU_ADD;
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          if (B == '0)                state_d = ST_DONE;
          else if (ovf_in)            state_d = ST_DONE;
          else if (sgn_in && A[XLEN-1]) state_d = ST_NEG_A;
          else if (sgn_in && B[XLEN-1]) state_d = ST_NEG_B;
          else                        state_d = ST_CMP;
        end
      end
      ST_NEG_A: begin
        ALU_REQ = 1'b1;
        ALU_Y   = a_q;
        ALU_OP  = ALU_SUB;
        if (ALU_GNT) state_d = (sgn && b_q[XLEN-1]) ? ST_NEG_B : ST_CMP;
      end
      ST_NEG_B: begin
        ALU_REQ = 1'b1;
        ALU_Y   = b_q;
        ALU_OP  = ALU_SUB;
        if (ALU_GNT) state_d = ST_CMP;
      end
      ST_CMP: begin
        ALU_REQ = 1'b1;
        ALU_X   = rs;
        ALU_Y   = b_q;
        ALU_OP  = ALU_SLTU;
        if (ALU_GNT) state_d = lt ? step_next : ST_SUB;
      end
      ST_SUB: begin
        ALU_REQ = 1'b1;
        ALU_X   = rem_q;
        ALU_Y   = b_q;
        ALU_OP  = ALU_SUB;
        if (ALU_GNT) state_d = step_next;
      end
      ST_FIX: begin
        ALU_REQ = 1'b1;
        ALU_Y   = quot ? q_q : rem_q;
        ALU_OP  = ALU_SUB;
        if (ALU_GNT) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q  <= ST_IDLE;
      op_q     <= DIVOP_DIV;
      a_q      <= '0;
      b_q      <= '0;
      rem_q    <= '0;
      q_q      <= '0;
      result_q <= '0;
      count_q  <= '0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (START) begin
            op_q    <= op_in;
            a_q     <= A;
            b_q     <= B;
            rem_q   <= '0;
            q_q     <= '0;
            count_q <= 5'd31;
            neg_q_q <= sgn_in & (A[XLEN-1] ^ B[XLEN-1]);
            neg_r_q <= sgn_in & A[XLEN-1];
            if (B == '0)  result_q <= quot_in ? '1 : A;
            else if (ovf_in) result_q <= quot_in ? {1'b1, {(XLEN-1){1'b0}}} : '0;
          end
        end
        ST_NEG_A: if (ALU_GNT) a_q <= ALU_RESULT;
        ST_NEG_B: if (ALU_GNT) b_q <= ALU_RESULT;
        ST_CMP: begin
          if (ALU_GNT) begin
            rem_q <= rs;
            if (lt) begin
              q_q <= q_clr;
              // Final bit with no sign fix: publish straight from the updated values.
              if (last && !fix_needed) result_q <= quot ? q_clr : rs;
              if (!last) count_q <= count_q - 5'd1;
            end
          end
        end
        ST_SUB: begin
          if (ALU_GNT) begin
            rem_q <= ALU_RESULT;
            q_q   <= q_set;
            if (last && !fix_needed) result_q <= quot ? q_set : ALU_RESULT;
            if (!last) count_q <= count_q - 5'd1;
          end
        end
        ST_FIX: if (ALU_GNT) result_q <= ALU_RESULT;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_div_seq.sv
// Self-checking bench for alu_div_seq: behavioural ALU + arithmetic reference model, per-cycle checker.
module tb_alu_div_seq;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        START;
  logic [1:0]  OP_SEL;
  logic [31:0] A, B;
  logic        BUSY, DONE;
  logic [31:0] RESULT;
  logic        ALU_REQ, ALU_GNT;
  logic [31:0] ALU_X, ALU_Y, ALU_RESULT;
  logic [3:0]  ALU_OP;

  alu_div_seq #(.XLEN(32)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .START(START), .OP_SEL(OP_SEL), .A(A), .B(B),
    .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT), .ALU_REQ(ALU_REQ), .ALU_GNT(ALU_GNT),
    .ALU_X(ALU_X), .ALU_Y(ALU_Y), .ALU_OP(ALU_OP), .ALU_RESULT(ALU_RESULT)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] alu_fn(input logic [31:0] x, input logic [31:0] y, input logic [3:0] op);
    case (op)
      4'd0: return x + y;
      4'd1: return x - y;
      4'd2: return x & y;
      4'd3: return x | y;
      4'd4: return x ^ y;
      4'd5: return x << y[4:0];
      4'd6: return x >> y[4:0];
      4'd7: return $signed(x) >>> y[4:0];
      4'd8: return {31'd0, $signed(x) < $signed(y)};
      4'd9: return {31'd0, x < y};
      default: return 32'd0;
    endcase
  endfunction

  always_comb ALU_RESULT = alu_fn(ALU_X, ALU_Y, ALU_OP);

  function automatic logic [31:0] model_res(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return op[1] ? a : 32'hFFFFFFFF;
    if (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) return op[1] ? 32'd0 : 32'h80000000;
    case (op)
      2'd0:    return 32'(sa / sb);
      2'd1:    return a / b;
      2'd2:    return 32'(sa % sb);
      default: return a % b;
    endcase
  endfunction

  // Edges after the accepting edge until DONE is visible, with the ALU always granted.
  function automatic int model_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic        sgn;
    logic [31:0] ma, mb, mq;
    int          n;
    sgn = !op[0];
    if (b == 32'd0) return 0;
    if (sgn && a == 32'h80000000 && b == 32'hFFFFFFFF) return 0;
    ma = (sgn && a[31]) ? -a : a;
    mb = (sgn && b[31]) ? -b : b;
    mq = ma / mb;
    n  = 32 + $countones(mq);
    if (sgn && a[31]) n++;
    if (sgn && b[31]) n++;
    if (op[1] ? (sgn && a[31]) : (sgn && (a[31] ^ b[31]))) n++;
    return n;
  endfunction

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [67:0] act, input logic [67:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // phase: 0 idle, 1 operation in flight, 2 cycle after DONE, 3 expect reset state, 4 ignore
  int          phase = 4;
  int          edges, stalls, exp_base;
  logic [31:0] exp_res, held_result;
  logic        gnt_edge, prev_valid;
  logic [31:0] prev_x, prev_y;
  logic [3:0]  prev_op;

  always @(negedge CLK) begin
    if (!ALU_REQ) chk("alu_idle_zero", {ALU_X, ALU_Y, ALU_OP}, 68'd0);
    case (phase)
      0: begin
        chk("idle_busy", {67'd0, BUSY}, 68'd0);
        chk("idle_done", {67'd0, DONE}, 68'd0);
        chk("idle_req", {67'd0, ALU_REQ}, 68'd0);
        chk("idle_result_hold", {36'd0, RESULT}, {36'd0, held_result});
      end
      1: begin
        chk("op_busy", {67'd0, BUSY}, 68'd1);
        if (DONE) begin
          chk("result", {36'd0, RESULT}, {36'd0, exp_res});
          chk("latency", 68'(edges), 68'(exp_base + stalls));
          chk("done_req", {67'd0, ALU_REQ}, 68'd0);
          phase = 2;
        end else begin
          chk("op_req", {67'd0, ALU_REQ}, 68'd1);
          if (prev_valid && !gnt_edge)
            chk("stall_stable", {ALU_X, ALU_Y, ALU_OP}, {prev_x, prev_y, prev_op});
          prev_x = ALU_X;
          prev_y = ALU_Y;
          prev_op = ALU_OP;
          prev_valid = 1'b1;
        end
      end
      2: begin
        chk("post_done_busy", {67'd0, BUSY}, 68'd0);
        chk("post_done_pulse", {67'd0, DONE}, 68'd0);
        chk("post_done_result", {36'd0, RESULT}, {36'd0, exp_res});
        held_result = exp_res;
        phase = 0;
      end
      3: begin
        chk("rst_busy", {67'd0, BUSY}, 68'd0);
        chk("rst_done", {67'd0, DONE}, 68'd0);
        chk("rst_result", {36'd0, RESULT}, 68'd0);
        chk("rst_req", {67'd0, ALU_REQ}, 68'd0);
        held_result = 32'd0;
        phase = 0;
      end
      default: ;
    endcase
  end

  function automatic logic pick_gnt(input int edge_idx, input int stall_from, input int stall_len, input bit rand_gnt);
    if (stall_len > 0 && edge_idx >= stall_from && edge_idx < stall_from + stall_len) return 1'b0;
    if (rand_gnt) return ($urandom_range(0, 4) != 0);
    return 1'b1;
  endfunction

  task automatic finish_now();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  endtask

  // Called at posedge+1 with the DUT idle; returns at posedge+1 with the DUT idle again.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int stall_from, input int stall_len, input bit rand_gnt, input bit poke,
                        input bit use_lit, input logic [31:0] lit_res, input int lit_lat);
    int guard;
    OP_SEL   = op;
    A        = a;
    B        = b;
    START    = 1'b1;
    exp_res  = use_lit ? lit_res : model_res(op, a, b);
    exp_base = use_lit ? lit_lat : model_lat(op, a, b);
    @(posedge CLK); #1;
    START      = 1'b0;
    A          = $urandom;
    B          = $urandom;
    OP_SEL     = 2'($urandom_range(0, 3));
    edges      = 0;
    stalls     = 0;
    prev_valid = 1'b0;
    phase      = 1;
    ALU_GNT    = pick_gnt(1, stall_from, stall_len, rand_gnt);
    guard      = 0;
    forever begin
      @(negedge CLK); #1;
      if (phase != 1) break;
      if (guard >= 300) begin
        n_cmp++;
        n_bad++;
        $display("FAIL done_timeout: got no DONE after %0d edges, expected %0d", edges, exp_base + stalls);
        finish_now();
      end
      @(posedge CLK); #1;
      guard++;
      edges++;
      gnt_edge = ALU_GNT;
      if (!ALU_GNT) stalls++;
      ALU_GNT = pick_gnt(edges + 1, stall_from, stall_len, rand_gnt);
      START   = poke && (edges == 5);
      if (START) begin
        A = $urandom;
        B = $urandom_range(1, 9);
      end
    end
    START = 1'b0;
    @(posedge CLK); #1;
    @(negedge CLK); #1;
    @(posedge CLK); #1;
  endtask

  function automatic logic [31:0] rand_operand(input bit allow_zero);
    case ($urandom_range(0, 6))
      0: return 32'($urandom_range(1, 20));
      1: return -32'($urandom_range(1, 20));
      2: return 32'h80000000;
      3: return 32'hFFFFFFFF;
      4: return allow_zero ? 32'd0 : 32'd3;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    RESET_N     = 1'b0;
    START       = 1'b0;
    OP_SEL      = 2'd0;
    A           = 32'd0;
    B           = 32'd0;
    ALU_GNT     = 1'b1;
    held_result = 32'd0;
    gnt_edge    = 1'b1;
    prev_valid  = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    RESET_N = 1'b1;
    phase   = 3;
    @(negedge CLK); #1;
    @(posedge CLK); #1;

    // Directed cases with hand-computed results and latencies (edges after the accepting edge).
    run_op(2'd1, 32'd100, 32'd7, 0, 0, 0, 0, 1, 32'd14, 35);
    run_op(2'd3, 32'd100, 32'd7, 0, 0, 0, 0, 1, 32'd2, 35);
    run_op(2'd0, 32'hFFFFFFF9, 32'd2, 0, 0, 0, 0, 1, 32'hFFFFFFFD, 36);
    run_op(2'd2, 32'hFFFFFFF9, 32'd2, 0, 0, 0, 0, 1, 32'hFFFFFFFF, 36);
    run_op(2'd0, 32'd7, 32'hFFFFFFFE, 0, 0, 0, 0, 1, 32'hFFFFFFFD, 36);
    run_op(2'd1, 32'd5, 32'd0, 0, 0, 0, 0, 1, 32'hFFFFFFFF, 0);
    run_op(2'd2, 32'd5, 32'd0, 0, 0, 0, 0, 1, 32'd5, 0);
    run_op(2'd0, 32'h80000000, 32'hFFFFFFFF, 0, 0, 0, 0, 1, 32'h80000000, 0);
    run_op(2'd2, 32'h80000000, 32'hFFFFFFFF, 0, 0, 0, 0, 1, 32'd0, 0);
    // Five ungranted cycles during the CMP run, plus a START pulse while busy.
    run_op(2'd1, 32'd100, 32'd7, 10, 5, 0, 1, 1, 32'd14, 35);

    // Reset on the tenth edge of an operation in flight.
    OP_SEL  = 2'd1;
    A       = 32'hFFFFFFFF;
    B       = 32'd3;
    START   = 1'b1;
    exp_res = 32'd0;
    @(posedge CLK); #1;
    START      = 1'b0;
    edges      = 0;
    stalls     = 0;
    exp_base   = 1000;
    prev_valid = 1'b0;
    ALU_GNT    = 1'b1;
    phase      = 1;
    while (edges < 10) begin
      @(posedge CLK); #1;
      edges++;
      gnt_edge = 1'b1;
    end
    RESET_N = 1'b0;
    phase   = 4;
    @(posedge CLK); #1;
    RESET_N = 1'b1;
    phase   = 3;
    @(negedge CLK); #1;
    @(posedge CLK); #1;
    run_op(2'd1, 32'd9, 32'd3, 0, 0, 0, 0, 1, 32'd3, 34);

    // Randomized operations against the reference model, with random grant stalls.
    for (int i = 0; i < 40; i++) begin
      run_op(2'($urandom_range(0, 3)), rand_operand(1'b0), rand_operand(1'b1),
             0, 0, 1, (i % 7) == 3, 0, 32'd0, 0);
    end

    finish_now();
  end

endmodule
